// File: rtl/io_stall_controller.sv
// io_stall_controller: sequences the IN and OUT instructions.
// IN stalls the PC until a debounced press of `ready`, then latches the
// switches and releases the pipeline for one retire cycle.
// OUT latches the register value into the display register and can
// optionally hold the PC for OUT_HOLD extra cycles so the value stays visible.
module io_stall_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,  // 1..255
   parameter int unsigned OUT_HOLD        = 0   // 0..255
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        io_in_req,
   input  logic        io_out_req,
   input  logic        ready,
   input  logic [15:0] switches,
   input  logic [31:0] out_data,
   output logic        stall,
   output logic [15:0] in_data,
   output logic        in_valid,
   output logic [31:0] display,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RELEASE,
      WAIT_PRESS,
      HOLD,
      DONE
   } state_t;

   // Terminal counts; the HOLD value wraps when OUT_HOLD is 0, but HOLD is
   // never entered in that configuration.
   localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(OUT_HOLD - 1);
   localparam bit         HAS_HOLD  = (OUT_HOLD != 0);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        sync1_q;
   logic        sync2_q;      // ready_s: the only view of the button we trust
   logic        done_is_in_q;
   logic [15:0] in_data_q;
   logic [31:0] display_q;
   logic        err_q;

   // Two-flop synchronizer plus the IN/OUT sequencer; cnt is cleared on every state change.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         done_is_in_q <= 1'b0;
         in_data_q    <= 16'd0;
         display_q    <= 32'd0;
         err_q        <= 1'b0;
      end else begin
         sync1_q <= ready;
         sync2_q <= sync1_q;
         case (state_q)
            IDLE: begin
               if (io_in_req) begin
                  // IN wins a conflict; the OUT half is dropped but remembered as an error.
                  if (io_out_req) err_q <= 1'b1;
                  cnt_q   <= 8'd0;
                  // A button already held when IN arrives is not a new press.
                  state_q <= sync2_q ? WAIT_RELEASE : WAIT_PRESS;
               end else if (io_out_req) begin
                  display_q <= out_data;
                  if (HAS_HOLD) begin
                     cnt_q   <= 8'd0;
                     state_q <= HOLD;
                  end
               end
            end
            WAIT_RELEASE: begin
               if (!sync2_q) begin
                  cnt_q   <= 8'd0;
                  state_q <= WAIT_PRESS;
               end
            end
            WAIT_PRESS: begin
               if (!sync2_q) begin
                  cnt_q <= 8'd0;               // bounce: restart the run of highs
               end else if (cnt_q == DEB_LAST) begin
                  in_data_q    <= switches;    // switches sampled at this edge only
                  done_is_in_q <= 1'b1;
                  cnt_q        <= 8'd0;
                  state_q      <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  done_is_in_q <= 1'b0;
                  cnt_q        <= 8'd0;
                  state_q      <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               // Requests still present here belong to the retiring instruction.
               cnt_q   <= 8'd0;
               state_q <= IDLE;
            end
            default: begin
               cnt_q   <= 8'd0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Stall decode; held low while reset is asserted so a pending request
   // cannot freeze the PC before the sequencer is running.
   always_comb begin
      stall = 1'b0;
      if (n_reset) begin
         case (state_q)
            IDLE:                          stall = io_in_req | (io_out_req & HAS_HOLD);
            WAIT_RELEASE, WAIT_PRESS, HOLD: stall = 1'b1;
            default:                       stall = 1'b0;
         endcase
      end
   end

   assign in_valid = n_reset & (state_q == DONE) & done_is_in_q;
   assign in_data  = in_data_q;
   assign display  = display_q;
   assign err      = err_q;

endmodule

// File: tb/tb_io_stall_controller.sv
// Bench for io_stall_controller: two instances (DEBOUNCE_CYCLES=4/OUT_HOLD=0
// and DEBOUNCE_CYCLES=1/OUT_HOLD=3) share stimulus and are checked every cycle
// against a behavioural model, plus directed scenarios with literal timing.
module tb_io_stall_controller;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        io_in_req;
   logic        io_out_req;
   logic        ready;
   logic [15:0] switches;
   logic [31:0] out_data;

   logic [1:0]  stall_v;
   logic [1:0]  in_valid_v;
   logic [1:0]  err_v;
   logic [15:0] in_data_v [N];
   logic [31:0] display_v [N];

   int checks   = 0;
   int failures = 0;
   bit armed    = 1'b0;

   always #5 clk = ~clk;

   io_stall_controller #(.DEBOUNCE_CYCLES(4), .OUT_HOLD(0)) dut0 (
      .clk(clk), .n_reset(n_reset), .io_in_req(io_in_req), .io_out_req(io_out_req),
      .ready(ready), .switches(switches), .out_data(out_data),
      .stall(stall_v[0]), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
      .display(display_v[0]), .err(err_v[0]));

   io_stall_controller #(.DEBOUNCE_CYCLES(1), .OUT_HOLD(3)) dut1 (
      .clk(clk), .n_reset(n_reset), .io_in_req(io_in_req), .io_out_req(io_out_req),
      .ready(ready), .switches(switches), .out_data(out_data),
      .stall(stall_v[1]), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
      .display(display_v[1]), .err(err_v[1]));

   function automatic int deb(int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int ohold(int i);
      return (i == 0) ? 0 : 3;
   endfunction

   // ---------------- behavioural model ----------------
   // An instance is either free, waiting on the operator (possibly for a
   // release first), counting down an OUT hold, or in its retire cycle.
   bit          m_pipe   [N];   // first synchronizer stage
   bit          m_rs     [N];   // ready as the controller sees it
   bit          m_wait_in[N];
   bit          m_need_rel[N];
   int          m_run    [N];   // consecutive highs seen while waiting for a press
   int          m_left   [N];   // OUT hold cycles still to go
   bit          m_retire [N];
   bit          m_ret_in [N];
   bit          m_err    [N];
   logic [15:0] m_in     [N];
   logic [31:0] m_disp   [N];
   bit          m_seen;

   function automatic bit exp_stall(int i);
      if (!n_reset || m_retire[i]) return 1'b0;
      if (m_wait_in[i] || m_left[i] > 0) return 1'b1;
      return io_in_req || (io_out_req && ohold(i) > 0);
   endfunction

   function automatic bit exp_valid(int i);
      return n_reset && m_retire[i] && m_ret_in[i];
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!n_reset) begin
            m_pipe[i] = 0; m_rs[i] = 0; m_wait_in[i] = 0; m_need_rel[i] = 0;
            m_run[i] = 0; m_left[i] = 0; m_retire[i] = 0; m_ret_in[i] = 0;
            m_err[i] = 0; m_in[i] = '0; m_disp[i] = '0;
         end else begin
            m_seen    = m_rs[i];
            m_rs[i]   = m_pipe[i];
            m_pipe[i] = ready;
            if (m_retire[i]) begin
               m_retire[i] = 0;
            end else if (m_wait_in[i]) begin
               if (m_need_rel[i]) begin
                  if (!m_seen) m_need_rel[i] = 0;
               end else if (!m_seen) begin
                  m_run[i] = 0;
               end else begin
                  m_run[i]++;
                  if (m_run[i] == deb(i)) begin
                     m_in[i]      = switches;
                     m_wait_in[i] = 0;
                     m_retire[i]  = 1;
                     m_ret_in[i]  = 1;
                  end
               end
            end else if (m_left[i] > 0) begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  m_retire[i] = 1;
                  m_ret_in[i] = 0;
               end
            end else if (io_in_req) begin
               if (io_out_req) m_err[i] = 1;
               m_wait_in[i]  = 1;
               m_need_rel[i] = m_seen;
               m_run[i]      = 0;
            end else if (io_out_req) begin
               m_disp[i] = out_data;
               m_left[i] = ohold(i);
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < N; i++) begin
            chk($sformatf("model_stall%0d", i),    32'(stall_v[i]),    32'(exp_stall(i)));
            chk($sformatf("model_in_valid%0d", i), 32'(in_valid_v[i]), 32'(exp_valid(i)));
            chk($sformatf("model_in_data%0d", i),  32'(in_data_v[i]),  32'(m_in[i]));
            chk($sformatf("model_display%0d", i),  display_v[i],       m_disp[i]);
            chk($sformatf("model_err%0d", i),      32'(err_v[i]),      32'(m_err[i]));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      n_reset    = 1'b0;
      io_in_req  = 1'b0;
      io_out_req = 1'b0;
      ready      = 1'b0;
      step();
      n_reset = 1'b1;
   endtask

   // Called right after an edge with dut0 waiting for a press and ready_s low:
   // raises ready and expects the capture cycle exactly six edges later.
   task automatic press_check(logic [15:0] d, string tag);
      ready = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         step();
         @(negedge clk);
         chk({tag, "_stall_wait"}, 32'(stall_v[0]), 32'd1);
      end
      step();
      @(negedge clk);
      chk({tag, "_in_valid"}, 32'(in_valid_v[0]), 32'd1);
      chk({tag, "_stall_done"}, 32'(stall_v[0]), 32'd0);
      chk({tag, "_in_data"}, 32'(in_data_v[0]), 32'(d));
   endtask

   logic pat [7];

   initial begin
      n_reset    = 1'b0;
      io_in_req  = 1'b1;
      io_out_req = 1'b0;
      ready      = 1'b1;
      switches   = 16'h0000;
      out_data   = 32'h0;
      pat        = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset held two cycles with a pending IN and the button down.
      step();
      armed = 1'b1;
      step();
      @(negedge clk);
      chk("rst_stall",   32'(stall_v[0]),   32'd0);
      chk("rst_in_data", 32'(in_data_v[0]), 32'd0);
      chk("rst_display", display_v[0],      32'd0);
      chk("rst_err",     32'(err_v[0]),     32'd0);
      step();
      n_reset = 1'b1;
      @(negedge clk);
      chk("rst_release_stall", 32'(stall_v[0]), 32'd1);

      // Clean IN.
      reset_pulse();
      switches = 16'hA5C3;
      step();
      io_in_req = 1'b1;
      step();
      step();
      press_check(16'hA5C3, "clean");
      step();
      @(negedge clk);
      chk("clean_no_recapture", 32'(in_valid_v[0]), 32'd0);
      chk("clean_hold_data",    32'(in_data_v[0]),  32'h0000A5C3);

      // Bounce: only the last four consecutive highs count.
      reset_pulse();
      switches  = 16'h1234;
      step();
      io_in_req = 1'b1;
      step();
      step();
      ready    = pat[0];
      switches = 16'h0001;
      for (int p = 1; p <= 9; p++) begin
         step();
         ready = (p < 7) ? pat[p] : 1'b1;
         @(negedge clk);
         if (p < 9) begin
            chk("bounce_stall", 32'(stall_v[0]), 32'd1);
         end else begin
            chk("bounce_in_valid", 32'(in_valid_v[0]), 32'd1);
            chk("bounce_in_data",  32'(in_data_v[0]),  32'h00000001);
         end
      end

      // Held button: no capture until released and pressed again.
      reset_pulse();
      switches = 16'h5A5A;
      ready    = 1'b1;
      step();
      step();
      step();
      io_in_req = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         @(negedge clk);
         chk("held_stall", 32'(stall_v[0]),    32'd1);
         chk("held_valid", 32'(in_valid_v[0]), 32'd0);
      end
      step();
      ready = 1'b0;
      step();
      step();
      step();
      press_check(16'h5A5A, "held");

      // OUT with and without hold.
      reset_pulse();
      io_out_req = 1'b1;
      out_data   = 32'hFFFF_FF9C;
      @(negedge clk);
      chk("out0_stall_req", 32'(stall_v[0]), 32'd0);
      chk("out3_stall_req", 32'(stall_v[1]), 32'd1);
      step();
      io_out_req = 1'b0;
      out_data   = 32'h0;
      @(negedge clk);
      chk("out0_display", display_v[0], 32'hFFFF_FF9C);
      chk("out3_display", display_v[1], 32'hFFFF_FF9C);
      chk("out0_stall",   32'(stall_v[0]), 32'd0);
      for (int e = 2; e <= 3; e++) begin
         step();
         @(negedge clk);
         chk("out3_hold_stall", 32'(stall_v[1]), 32'd1);
      end
      step();
      @(negedge clk);
      chk("out3_done_stall", 32'(stall_v[1]),    32'd0);
      chk("out3_done_valid", 32'(in_valid_v[1]), 32'd0);

      // Conflict, then reset in the middle of the IN wait.
      reset_pulse();
      out_data   = 32'h1234_5678;
      io_in_req  = 1'b1;
      io_out_req = 1'b1;
      step();
      io_out_req = 1'b0;
      @(negedge clk);
      chk("conf_err",     32'(err_v[0]),   32'd1);
      chk("conf_display", display_v[0],    32'd0);
      chk("conf_stall",   32'(stall_v[0]), 32'd1);
      step();
      step();
      switches = 16'hBEEF;
      n_reset  = 1'b0;
      step();
      @(negedge clk);
      chk("midrst_err",   32'(err_v[0]),   32'd0);
      chk("midrst_stall", 32'(stall_v[0]), 32'd0);
      n_reset   = 1'b1;
      io_in_req = 1'b0;
      step();
      @(negedge clk);
      chk("midrst_stall_idle", 32'(stall_v[0]),   32'd0);
      chk("midrst_in_data",    32'(in_data_v[0]), 32'd0);

      // Randomized traffic checked by the model.
      for (int c = 0; c < 3000; c++) begin
         step();
         n_reset    = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 5) == 0) ready = ~ready;
         io_in_req  = ($urandom_range(0, 3) == 0);
         io_out_req = ($urandom_range(0, 3) == 0);
         switches   = 16'($urandom);
         out_data   = $urandom;
      end
      step();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/io_stall_controller.md
Name: io_stall_controller

Overview:
- Multi-cycle sequencer for the processor's IN and OUT instructions, placed between the control unit and the PC, register bank and output module.
- For IN, it stalls the PC until the operator presses `ready`, then presents a latched `switches` value to the immediate/switch mux for exactly one retire cycle.
- For OUT, it latches the value into a display register and can optionally hold the PC so the value stays visible.
- It replaces the ad-hoc use of raw `ready` in the control unit.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized-high cycles of `ready` that count as a press; legal range 1..255.
- OUT_HOLD, 0: stall cycles added after an OUT; 0 means OUT completes with no stall; legal range 0..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- n_reset  in  1  synchronous active-low reset.
- io_in_req  in  1  current instruction is IN; held by the decoder while the instruction is current.
- io_out_req  in  1  current instruction is OUT.
- ready  in  1  operator button, active high, asynchronous.
- switches  in  16  operator data.
- out_data  in  32  register value to display (register bank port A).
- stall  out  1  freezes the PC and inhibits register and memory writes while high.
- in_data  out  16  latched switch value, routed to the switch input of the 16-bit mux.
- in_valid  out  1  high in the single cycle the IN instruction retires.
- display  out  32  latched display value, routed to the output module.
- err  out  1  sticky flag: io_in_req and io_out_req were seen high together.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous, active-low, sampled on the rising clk edge.
  - On reset: state=IDLE, cnt=0, sync flops=0, in_data=0, display=0, err=0. Combinationally this gives stall=0 unless IDLE with a request, and in_valid=0.
  - Reset mid-operation aborts any wait; no partial latch survives.
- Synchronizer: `ready` passes through two flops to give ready_s, so 2 cycles of latency. Only ready_s is used.
- Counter: cnt is 8-bit, cleared on every state change.
- States: IDLE, WAIT_RELEASE, WAIT_PRESS, HOLD, DONE.
- stall (combinational) is high when any of these holds:
  - state is IDLE and io_in_req=1;
  - state is IDLE, io_out_req=1 and OUT_HOLD>0;
  - state is WAIT_RELEASE, WAIT_PRESS or HOLD.
- stall is 0 in DONE.
- in_valid = (state==DONE && done_is_in). done_is_in is a flop set on entry to DONE from WAIT_PRESS.
- IDLE transitions:
  - io_in_req=1 and ready_s=1: go to WAIT_RELEASE. A button already held does not count as a new press.
  - io_in_req=1 and ready_s=0: go to WAIT_PRESS.
  - io_out_req=1 (no io_in_req): display<=out_data at that edge. If OUT_HOLD=0, stay in IDLE; the instruction retires in the same cycle. Otherwise go to HOLD.
  - Both requests high: IN takes priority, OUT is ignored, err<=1. err is cleared only by reset.
- WAIT_RELEASE: when ready_s=0, go to WAIT_PRESS.
- WAIT_PRESS:
  - While ready_s=1, cnt increments.
  - When ready_s=0, cnt<=0 (a bounce restarts the count).
  - When ready_s=1 and cnt==DEBOUNCE_CYCLES-1: in_data<=switches, then go to DONE.
  - switches is sampled at that edge only.
- HOLD: cnt increments each cycle; when cnt==OUT_HOLD-1, go to DONE.
- DONE:
  - One cycle with stall=0, so the instruction retires. The IN writes in_data through the datapath.
  - Always returns to IDLE. Requests still high in DONE are ignored, which prevents re-triggering the same instruction.
  - A request in the following IDLE cycle is a new instruction.
- Latency:
  - Minimum IN = 2 (sync) + DEBOUNCE_CYCLES + 1 (DONE) cycles after the press edge.
  - OUT = 1 cycle when OUT_HOLD=0; otherwise OUT_HOLD+2 cycles.
- display and in_data hold their values until overwritten or reset.

Test Plan:
- Reset: n_reset=0 for 2 cycles while ready=1 and io_in_req=1 -> stall=0, in_data=0, display=0, err=0. After release, stall=1 on the first cycle with io_in_req=1.
- Clean IN: DEBOUNCE_CYCLES=4, switches=16'hA5C3, ready low, then io_in_req=1, then ready=1 held:
  - stall stays high until the cycle 7 cycles after ready rises;
  - in that cycle stall=0, in_valid=1 and in_data=16'hA5C3;
  - then IDLE, with no second capture while io_in_req is still high in DONE.
- Bounce: ready pattern 1,1,0,1,1,1,1 during WAIT_PRESS -> capture only after the last four consecutive highs (plus 2 cycles of sync delay). Changing switches to 16'h0001 before the capture edge gives in_data=16'h0001.
- Held button: ready=1 before io_in_req -> no capture until ready falls and rises again for 4 cycles.
- OUT: OUT_HOLD=0 with io_out_req=1 and out_data=32'hFFFF_FF9C -> display=32'hFFFF_FF9C next cycle, stall=0 throughout. With OUT_HOLD=3 -> stall high for 4 cycles, then one DONE cycle.
- Conflict plus mid-op reset: io_in_req=io_out_req=1 -> err=1, display unchanged, IN sequence runs. Reset asserted during WAIT_PRESS -> IDLE, err=0, no capture.
